ahbl_excl_sram: RTL and testbench



---
 rtl/ahbl_pkg.sv | 38 +++
 rtl/ahbl_excl_monitor.sv | 58 +++++
 rtl/ahbl_excl_sram.sv | 155 +++++++++++++++
 tb/tb_ahbl_excl_sram.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// ==== ahbl_pkg : AHB-Lite encodings and data-phase FSM states shared by the SRAM slave ====
// ==== Rev 1.0                                                                           ====
`default_nettype none

package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
    misaligned = (size > HSIZE_WORD) ||
                 ((size == HSIZE_HALF) && addr[0]) ||
                 ((size == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahbl_excl_monitor.sv
// ==== ahbl_excl_monitor : per-master {valid, word} reservation slots for LR/SC ====
// ==== Rev 1.0                                                                 ====
`default_nettype none

module ahbl_excl_monitor
  import ahbl_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int W_MIDX    = 1,
  parameter int W_WORD    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit,
  input  logic              is_write,
  input  logic              is_excl,
  input  logic              master_ok,
  input  logic [W_MIDX-1:0] master_idx,
  input  logic [W_WORD-1:0] word_addr,
  output logic              okay
);

  logic [N_MASTERS-1:0] res_vld;
  logic [W_WORD-1:0]    res_word [N_MASTERS];

  always_comb begin
    okay = 1'b0;
    if (master_ok && is_excl) begin
      if (!is_write)
        okay = 1'b1;
      else
        okay = res_vld[master_idx] && (res_word[master_idx] == word_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_vld <= '0;
    end else if (commit) begin
      if (is_write) begin
        if (!is_excl || okay) begin
          // Any committed store kills every reservation on that word.
          for (int i = 0; i < N_MASTERS; i++)
            if (res_vld[i] && (res_word[i] == word_addr))
              res_vld[i] <= 1'b0;
        end else if (master_ok) begin
          res_vld[master_idx] <= 1'b0;
        end
      end else if (is_excl && master_ok) begin
        res_vld[master_idx]  <= 1'b1;
        res_word[master_idx] <= word_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahbl_excl_sram.sv
// ==== ahbl_excl_sram : AHB-Lite SRAM slave with wait states, ERROR on misalignment ====
// ==== and an exclusive-access monitor.  Rev 1.0                                    ====
`default_nettype none

module ahbl_excl_sram
  import ahbl_pkg::*;
#(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int N_MASTERS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              ahbls_hexcl,
  input  logic [7:0]        ahbls_hmaster,
  output logic              ahbls_hexokay
);

  localparam int         W_IDX     = $clog2(DEPTH);
  localparam int         W_MIDX    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int         NB        = W_DATA / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]        state;
  logic [3:0]        wait_cnt;
  logic [W_IDX-1:0]  idx_q;
  logic              write_q;
  logic              excl_q;
  logic [W_MIDX-1:0] midx_q;
  logic              mok_q;
  logic [NB-1:0]     be_q;

  logic              ready;
  logic              accept;
  logic              mem_we;
  logic              mon_commit;
  logic              mon_okay;
  logic [W_IDX-1:0]  rd_idx;
  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_DATA-1:0] rdata_raw;
  logic [W_DATA-1:0] byp_data;
  logic [NB-1:0]     byp_be;
  logic [W_DATA-1:0] merged;
  logic              unused_ok;

  assign ready  = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign accept = ready && ahbls_hready && ahbls_htrans[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_LAST;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          if (!accept) begin
            state <= ST_IDLE;
          end else if (misaligned(ahbls_hsize, ahbls_haddr[1:0])) begin
            state <= ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end else begin
            state <= ST_LAST;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= ahbls_haddr[2 +: W_IDX];
      write_q <= ahbls_hwrite;
      excl_q  <= ahbls_hexcl;
      midx_q  <= ahbls_hmaster[W_MIDX-1:0];
      mok_q   <= ({24'd0, ahbls_hmaster} < 32'(N_MASTERS));
      be_q    <= byte_en(ahbls_hsize, ahbls_haddr[1:0]);
    end
  end

  // A failed exclusive store must leave the SRAM untouched.
  assign mon_commit = rst_n && (state == ST_LAST);
  assign mem_we     = mon_commit && write_q && (!excl_q || mon_okay);
  assign rd_idx     = (state == ST_WAIT) ? idx_q : ahbls_haddr[2 +: W_IDX];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (mem_we && be_q[b])
        mem[idx_q][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
    rdata_raw <= mem[rd_idx];
    byp_data  <= ahbls_hwdata;
  end

  // The array read above sees pre-write data when a read address phase lands
  // on a committing write's LAST cycle; remember which lanes to patch.
  always_ff @(posedge clk) begin
    if (!rst_n)
      byp_be <= '0;
    else
      byp_be <= (mem_we && (rd_idx == idx_q)) ? be_q : '0;
  end

  always_comb begin
    merged = rdata_raw;
    for (int b = 0; b < NB; b++)
      if (byp_be[b]) merged[8*b +: 8] = byp_data[8*b +: 8];
  end

  ahbl_excl_monitor #(
    .N_MASTERS (N_MASTERS),
    .W_MIDX    (W_MIDX),
    .W_WORD    (W_IDX)
  ) u_monitor (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (mon_commit),
    .is_write   (write_q),
    .is_excl    (excl_q),
    .master_ok  (mok_q),
    .master_idx (midx_q),
    .word_addr  (idx_q),
    .okay       (mon_okay)
  );

  assign ahbls_hready_resp = !((state == ST_WAIT) || (state == ST_ERR1));
  assign ahbls_hresp       = (state == ST_ERR1) || (state == ST_ERR2);
  assign ahbls_hexokay     = (state == ST_LAST) && excl_q && mon_okay;
  assign ahbls_hrdata      = ((state == ST_LAST) && !write_q) ? merged : '0;

  assign unused_ok = &{1'b0, ahbls_haddr, ahbls_htrans[0], ahbls_hburst,
                       ahbls_hprot, ahbls_hmastlock};

endmodule

`default_nettype wire

// File: tb/tb_ahbl_excl_sram.sv
// ==== tb_ahbl_excl_sram : scoreboard bench, one DUT with 0 and one with 2 wait states ====
// ==== Rev 1.0                                                                         ====
`default_nettype none

module tb_ahbl_excl_sram;
  import ahbl_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic        hexcl = 1'b0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [7:0]  hmaster = '0;

  logic [1:0][1:0]  htrans_d;
  logic [1:0]       rdy, resp, exok;
  logic [1:0][31:0] rdata;
  logic             s_rdy, s_resp, s_exok;
  logic [31:0]      s_rdata;

  assign htrans_d[0] = (sel == 1'b0) ? htrans : HTRANS_IDLE;
  assign htrans_d[1] = (sel == 1'b1) ? htrans : HTRANS_IDLE;
  assign s_rdy   = rdy[sel];
  assign s_resp  = resp[sel];
  assign s_exok  = exok[sel];
  assign s_rdata = rdata[sel];

  ahbl_excl_sram #(.WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(rdy[0]), .ahbls_hready_resp(rdy[0]),
    .ahbls_hresp(resp[0]), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
    .ahbls_htrans(htrans_d[0]), .ahbls_hsize(hsize), .ahbls_hburst(3'b000),
    .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(rdata[0]), .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster),
    .ahbls_hexokay(exok[0]));

  ahbl_excl_sram #(.WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(rdy[1]), .ahbls_hready_resp(rdy[1]),
    .ahbls_hresp(resp[1]), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
    .ahbls_htrans(htrans_d[1]), .ahbls_hsize(hsize), .ahbls_hburst(3'b000),
    .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(rdata[1]), .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster),
    .ahbls_hexokay(exok[1]));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    bit          excl;
    logic [7:0]  mst;
    logic [31:0] wdata;
    string       tag;
  } txn_t;

  typedef struct {
    string       tag;
    bit          rd;
    logic [31:0] rdata;
    bit          okay;
    bit          err;
  } exp_t;

  txn_t        cmd_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem [2][1024];
  bit          res_v [2][2];
  int          res_w [2][2];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic put(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                     input bit excl, input logic [7:0] mst, input logic [31:0] wdata,
                     input string tag);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.excl = excl;
    t.mst = mst; t.wdata = wdata; t.tag = tag;
    cmd_q.push_back(t);
  endtask

  // Reference model of one transfer, applied in bus order.
  task automatic predict(input txn_t t, output exp_t e);
    int  d, w, m, off, nb;
    bit  mok, succ;
    d   = int'(sel);
    w   = int'(t.addr[11:2]);
    mok = (t.mst < 8'd2);
    m   = int'(t.mst[0]);
    e.tag = t.tag; e.rd = !t.wr; e.rdata = '0; e.okay = 1'b0; e.err = 1'b0;
    if ((t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
        (t.size == 3'd2 && t.addr[1:0] != 2'b00)) begin
      e.err = 1'b1;
      return;
    end
    if (!t.wr) begin
      e.rdata = ref_mem[d][w];
      if (t.excl && mok) begin
        res_v[d][m] = 1'b1;
        res_w[d][m] = w;
        e.okay = 1'b1;
      end
      return;
    end
    succ = !t.excl || (mok && res_v[d][m] && res_w[d][m] == w);
    if (succ) begin
      off = int'(t.addr[1:0]);
      nb  = 1 << int'(t.size);
      for (int b = 0; b < 4; b++)
        if (b >= off && b < off + nb) ref_mem[d][w][8*b +: 8] = t.wdata[8*b +: 8];
      for (int i = 0; i < 2; i++)
        if (res_v[d][i] && res_w[d][i] == w) res_v[d][i] = 1'b0;
      e.okay = t.excl;
    end else if (mok) begin
      res_v[d][m] = 1'b0;
    end
  endtask

  task automatic present();
    if (cmd_q.size() > 0) begin
      haddr = cmd_q[0].addr; hwrite = cmd_q[0].wr; hsize = cmd_q[0].size;
      hexcl = cmd_q[0].excl; hmaster = cmd_q[0].mst; htrans = HTRANS_NSEQ;
    end else begin
      htrans = HTRANS_IDLE; hexcl = 1'b0;
    end
  endtask

  // Runs the pipelined bus until every queued command has completed.
  task automatic drain();
    txn_t dph;
    exp_t e;
    bit   dvalid = 1'b0;
    bit   r, pres;
    int   stall = 0;
    int   guard = 0;
    int   ws;
    ws = sel ? WS1 : WS0;
    present();
    while (cmd_q.size() > 0 || dvalid) begin
      @(negedge clk);
      r = s_rdy;
      pres = (cmd_q.size() > 0);
      if (dvalid) begin
        if (!r) begin
          stall++;
          if (exp_q[0].err) check_eq({exp_q[0].tag, "/err1_hresp"}, 32'(s_resp), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq({e.tag, "/stalls"}, 32'(stall), e.err ? 32'd1 : 32'(ws));
          check_eq({e.tag, "/hresp"}, 32'(s_resp), 32'(e.err));
          check_eq({e.tag, "/hexokay"}, 32'(s_exok), 32'(e.okay));
          if (e.rd && !e.err) check_eq({e.tag, "/hrdata"}, s_rdata, e.rdata);
          stall = 0;
        end
      end
      @(posedge clk);
      #1;
      if (r) begin
        if (pres) begin
          dph = cmd_q.pop_front();
          predict(dph, e);
          exp_q.push_back(e);
          dvalid = 1'b1;
          hwdata = dph.wdata;
        end else begin
          dvalid = 1'b0;
          hwdata = '0;
        end
        present();
      end
      guard++;
      if (guard > 300) begin
        check_eq("drain_timeout", 32'(cmd_q.size() + exp_q.size()), 32'd0);
        cmd_q.delete();
        exp_q.delete();
        htrans = HTRANS_IDLE;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "/hready_resp"}, 32'(s_rdy), 32'd1);
    check_eq({tag, "/hresp"}, 32'(s_resp), 32'd0);
    check_eq({tag, "/hexokay"}, 32'(s_exok), 32'd0);
    check_eq({tag, "/hrdata"}, s_rdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; check_idle_outputs("reset_dut0");
    sel = 1'b1; #1; check_idle_outputs("reset_dut1");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain access, two wait states
    put(1, 32'h10, HSIZE_WORD, 0, 8'd0, 32'hDEADBEEF, "ws2_wr");
    put(0, 32'h10, HSIZE_WORD, 0, 8'd0, 32'h0, "ws2_rd");
    drain();

    // Zero wait states: byte write then back-to-back read through the bypass
    sel = 1'b0; #1;
    put(1, 32'h10, HSIZE_WORD, 0, 8'd0, 32'hDEADBEEF, "ws0_wr");
    put(1, 32'h13, HSIZE_BYTE, 0, 8'd0, 32'hAB000000, "byte_wr");
    put(0, 32'h10, HSIZE_WORD, 0, 8'd0, 32'h0, "bypass_rd");
    put(1, 32'h16, HSIZE_HALF, 0, 8'd1, 32'h1234_0000, "half_wr");
    put(0, 32'h14, HSIZE_WORD, 0, 8'd1, 32'h0, "half_rd");
    drain();

    // LR/SC success with misaligned transfers interleaved
    put(0, 32'h20, HSIZE_WORD, 1, 8'd0, 32'h0, "lr0");
    put(0, 32'h12, HSIZE_WORD, 0, 8'd0, 32'h0, "mis_word_rd");
    put(1, 32'h22, HSIZE_WORD, 1, 8'd0, 32'hFFFFFFFF, "mis_excl_wr");
    put(1, 32'h11, HSIZE_HALF, 0, 8'd0, 32'hFFFFFFFF, "mis_half_wr");
    put(0, 32'h10, 3'd3, 0, 8'd0, 32'h0, "mis_dword_rd");
    put(0, 32'h10, HSIZE_WORD, 0, 8'd0, 32'h0, "after_err_rd");
    put(1, 32'h20, HSIZE_WORD, 1, 8'd0, 32'h5, "sc0_ok");
    put(1, 32'h20, HSIZE_WORD, 1, 8'd0, 32'h6, "sc0_again");
    put(0, 32'h20, HSIZE_WORD, 0, 8'd0, 32'h0, "sc0_rd");
    drain();

    // LR/SC conflict between masters, plus an out-of-range master ID
    put(0, 32'h40, HSIZE_WORD, 1, 8'd0, 32'h0, "lr_m0");
    put(0, 32'h40, HSIZE_WORD, 1, 8'd1, 32'h0, "lr_m1");
    put(1, 32'h40, HSIZE_WORD, 0, 8'd1, 32'h7, "st_m1");
    put(1, 32'h40, HSIZE_WORD, 1, 8'd0, 32'h9, "sc_m0_fail");
    put(1, 32'h40, HSIZE_WORD, 1, 8'd1, 32'hB, "sc_m1_fail");
    put(0, 32'h40, HSIZE_WORD, 0, 8'd0, 32'h0, "conflict_rd");
    put(0, 32'h40, HSIZE_WORD, 1, 8'd5, 32'h0, "lr_m5");
    put(1, 32'h40, HSIZE_WORD, 1, 8'd5, 32'hC, "sc_m5");
    put(1, 32'h42, HSIZE_HALF, 0, 8'd0, 32'hCAFE0000, "half_hi_wr");
    put(0, 32'h40, HSIZE_WORD, 0, 8'd0, 32'h0, "half_hi_rd");
    drain();

    // Reset in the middle of an exclusive write's wait states
    sel = 1'b1; #1;
    put(1, 32'h30, HSIZE_WORD, 0, 8'd0, 32'h1111, "pre_wr");
    put(0, 32'h30, HSIZE_WORD, 1, 8'd0, 32'h0, "pre_lr");
    drain();
    haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD; hexcl = 1'b1; hmaster = 8'd0;
    htrans = HTRANS_NSEQ;
    @(posedge clk); #1;
    htrans = HTRANS_IDLE; hexcl = 1'b0; hwdata = 32'h2222;
    check_eq("mid_rst/in_wait", 32'(s_rdy), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("mid_rst");
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) res_v[d][m] = 1'b0;
    put(1, 32'h30, HSIZE_WORD, 1, 8'd0, 32'h3333, "post_rst_sc");
    put(0, 32'h30, HSIZE_WORD, 0, 8'd0, 32'h0, "post_rst_rd");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
